// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit RISC core: sequencer states,
// opcode classes and PC source selects.
package isa_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    // Branch target selected when the condition holds, PC+2 otherwise.
    function automatic logic [1:0] branch_src(input logic [3:0] op, input logic zero);
        logic taken;
        taken = (op == OP_BEQ) ? zero : ~zero;
        return taken ? PC_BR : PC_INC;
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-cycle counter shared by the FETCH and MEM handshakes; flags a bus
// timeout on the last permitted cycle unless the ack arrives on it.
module bus_wait_timer #(
    parameter int MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic       ack,
    output logic [7:0] wait_cnt,
    output logic       expired
);

    logic [7:0] wait_cnt_r;

    // Counter idles at zero outside a wait state so each wait starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 8'd0;
        end else if (!active || ack) begin
            wait_cnt_r <= 8'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end
    end

    assign wait_cnt = wait_cnt_r;
    assign expired  = active && !ack && (wait_cnt_r == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
// retire counter and sticky bus-timeout error.
module multicycle_sequencer
    import isa_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [3:0]         opcode,
    input  logic               alu_zero,
    output logic               imem_req,
    input  logic               imem_ack,
    output logic               ir_write,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               reg_write_en,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               busy,
    output logic [COUNT_W-1:0] instr_count,
    output logic               timeout_err
);

    state_e             state_r;
    state_e             next_state_s;
    state_e             after_retire_s;
    logic [COUNT_W-1:0] instr_count_r;
    logic               timeout_err_r;
    logic               retire_s;
    logic               timeout_s;
    logic               wait_active_s;
    logic               wait_ack_s;
    logic               wait_expired_s;
    logic [7:0]         wait_cnt_s;

    assign wait_active_s  = (state_r == S_FETCH) || (state_r == S_MEM);
    assign wait_ack_s     = (state_r == S_FETCH) ? imem_ack : dmem_ack;
    assign after_retire_s = run ? S_FETCH : S_IDLE;

    bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (wait_active_s),
        .ack      (wait_ack_s),
        .wait_cnt (wait_cnt_s),
        .expired  (wait_expired_s)
    );

    // Next-state and strobe decode; strobes depend on state and live inputs.
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        timeout_s    = 1'b0;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_write_en = 1'b0;
        pc_src       = PC_INC;
        case (state_r)
            S_IDLE: begin
                if (run) next_state_s = S_FETCH;
                else     next_state_s = S_IDLE;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write     = 1'b1;
                    next_state_s = S_DECODE;
                end else if (wait_expired_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = S_ERR;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: next_state_s = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_LD, OP_ST: next_state_s = S_MEM;
                    OP_BEQ, OP_BNE: begin
                        retire_s     = 1'b1;
                        pc_src       = branch_src(opcode, alu_zero);
                        next_state_s = after_retire_s;
                    end
                    OP_JMP: begin
                        retire_s     = 1'b1;
                        pc_src       = PC_JMP;
                        next_state_s = after_retire_s;
                    end
                    default: next_state_s = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_ST);
                if (dmem_ack) begin
                    if (opcode == OP_ST) begin
                        retire_s     = 1'b1;
                        next_state_s = after_retire_s;
                    end else begin
                        next_state_s = S_WB;
                    end
                end else if (wait_expired_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = S_ERR;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                reg_write_en = 1'b1;
                retire_s     = 1'b1;
                next_state_s = after_retire_s;
            end
            S_ERR:   next_state_s = S_ERR;
            default: next_state_s = S_ERR;
        endcase
    end

    // State, retire counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            instr_count_r <= {COUNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (retire_s) begin
                instr_count_r <= instr_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
            end else begin
                instr_count_r <= instr_count_r;
            end
            timeout_err_r <= timeout_err_r | timeout_s;
        end
    end

    assign pc_write    = retire_s;
    assign busy        = (state_r != S_IDLE) && (state_r != S_ERR);
    assign instr_count = instr_count_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the 16-bit RISC core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and performs the instruction- and data-memory req/ack handshakes.
- Generates per-cycle enables (IR load, PC update, register write) that gate the static decode produced by the combinational control unit.
- Sits between the control unit, the PC/IR registers and the memory ports; owns the retire counter and the bus-timeout error.

Parameters:
- MAX_WAIT, 8, max cycles FETCH or MEM may wait for ack before ERR (1..255)
- COUNT_W, 16, width of retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = keep issuing instructions
- opcode  input  4  opcode field of IR (valid from DECODE onward)
- alu_zero  input  1  ALU zero flag, sampled in EXEC
- imem_req  output  1  instruction fetch request
- imem_ack  input  1  instruction data valid this cycle
- ir_write  output  1  load IR from instruction bus
- dmem_req  output  1  data memory request
- dmem_we  output  1  1 = store, 0 = load (valid with dmem_req)
- dmem_ack  input  1  data access complete / load data valid
- reg_write_en  output  1  register-file write strobe
- pc_write  output  1  PC update strobe, exactly one per retired instruction
- pc_src  output  2  00 = PC+2, 01 = branch target, 10 = jump target
- busy  output  1  state != IDLE and != ERR
- instr_count  output  COUNT_W  retired instructions, wraps modulo 2^COUNT_W
- timeout_err  output  1  sticky bus-timeout flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; wait_cnt=0; instr_count=0; timeout_err=0; all strobes 0; pc_src=00. Any state is aborted immediately; no partial retire.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
- Outputs are combinational from state and inputs; state, wait_cnt, instr_count and timeout_err are registered.
- Opcode classes:
  - LD = 0000
  - ST = 0001
  - BEQ = 1011
  - BNE = 1100: branch only, no writeback
  - JMP = 1101
  - ALU = 0010, 0011, 0101 and all other codes
- "next" below means: FETCH if run=1, else IDLE.
- IDLE: go to FETCH when run=1.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_write=1 in the same cycle, go to DECODE.
- DECODE: one cycle, no strobes; go to EXEC.
- EXEC:
  - ALU: go to WB.
  - LD/ST: go to MEM.
  - BEQ: retire; pc_src=01 if alu_zero=1, else 00.
  - BNE: retire; pc_src=01 if alu_zero=0, else 00.
  - JMP: retire with pc_src=10.
  - Branches and JMP go to next.
- MEM:
  - dmem_req=1; dmem_we=1 for ST.
  - On dmem_ack: ST retires (pc_src=00) and goes to next; LD goes to WB.
- WB: reg_write_en=1; retire with pc_src=00; go to next.
- Retire cycle: pc_write=1 and instr_count+1 on the same clock edge. Minimum latencies: ALU 4 cycles with 0-wait ack; LD/ST 5/4; branch/JMP 3.
- wait_cnt:
  - Cleared on entering FETCH or MEM and on ack.
  - Increments each cycle in FETCH/MEM without ack.
  - When wait_cnt = MAX_WAIT-1 and no ack: go to ERR, timeout_err=1.
  - An ack arriving on that same cycle wins (no error).
- ERR: all strobes 0, busy=0, timeout_err held; exit only by reset.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- run=0 mid-instruction: the instruction completes; the sequencer stops in IDLE after retire.
- instr_count wraps from all-ones to 0 without a flag.

Decomposition:
- Package isa_pkg holds:
  - state enum (7 states, 3-bit)
  - opcode constants OP_LD, OP_ST, OP_BEQ, OP_BNE, OP_JMP
  - pc_src constants PC_INC, PC_BR, PC_JMP
- One sub-module, bus_wait_timer: wait_cnt plus the timeout compare, shared by the FETCH and MEM waits.

Test Plan:
- ALU op 0010, run=1, imem_ack on first FETCH cycle: ir_write at cycle 1, reg_write_en and pc_write (pc_src=00) at cycle 4, instr_count=1, back in FETCH at cycle 5.
- LD 0000 with dmem_ack delayed 3 cycles: dmem_req=1, dmem_we=0 for 4 cycles; WB one cycle later with reg_write_en=1; exactly one pc_write.
- BEQ with alu_zero=1 gives pc_src=01; BNE with alu_zero=1 gives pc_src=00; JMP gives pc_src=10. reg_write_en stays 0 throughout all three.
- Timeout: MAX_WAIT=8, imem_ack held 0 → ERR after 8 FETCH cycles, timeout_err=1, imem_req=0 afterwards. A later ack does nothing; rst_n pulse clears everything to reset values.
- run dropped during MEM of a ST: store completes on ack with pc_write=1, state goes to IDLE, busy=0, no further imem_req.
- rst_n asserted asynchronously mid-WB: outputs 0 before the next clock edge, instr_count unchanged from its pre-instruction value then cleared to 0.
